// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag sequencer for an external fifomem array (async read, registered write).
// Latency: 1 cycle write-to-read (no fall-through); flags are registered from next-count.
// Backpressure: wr_ready_o = !full, rd_valid_o = !empty; optional sticky ovf/udf flags under FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl #(
    parameter  int Depth    = 8,
    parameter  int AFullThr = Depth - 2,
    localparam int AWidth   = $clog2(Depth),
    localparam int CWidth   = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              mem_w_en_o,
    output logic [AWidth-1:0] mem_w_addr_o,
    output logic [AWidth-1:0] mem_r_addr_o,
    output logic [CWidth-1:0] count_o,
    output logic              full_o,
    output logic              empty_o,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    output logic              ovf_o,
    output logic              udf_o,
`endif
    output logic              almost_full_o
);

    localparam logic [AWidth-1:0] LastIdx = AWidth'(Depth - 1);
    localparam logic [CWidth-1:0] DepthC  = CWidth'(Depth);
    localparam logic [CWidth-1:0] AFullC  = CWidth'(AFullThr);

    logic [AWidth-1:0] wr_ptr;
    logic [AWidth-1:0] rd_ptr;
    logic [CWidth-1:0] count;
    logic [CWidth-1:0] count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              afull_q;
    logic              push;
    logic              pop;

    // Flags come straight from registers, so a pop at full cannot re-open
    // the write side in the same cycle.
    assign push = wr_valid_i & ~full_q;
    assign pop  = rd_ready_i & ~empty_q;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CWidth'(1);
        end else if (pop && !push) begin
            count_nxt = count - CWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LastIdx) ? '0 : wr_ptr + AWidth'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastIdx) ? '0 : rd_ptr + AWidth'(1);
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == DepthC);
            empty_q <= (count_nxt == '0);
            afull_q <= (count_nxt >= AFullC);
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_valid_i & full_q);
            udf_q <= udf_q | (rd_ready_i & empty_q);
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`endif

    assign wr_ready_o    = ~full_q;
    assign rd_valid_o    = ~empty_q;
    assign mem_w_en_o    = push;
    assign mem_w_addr_o  = wr_ptr;
    assign mem_r_addr_o  = rd_ptr;
    assign count_o       = count;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign almost_full_o = afull_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: Depth=8 (AFullThr=6) and Depth=5 instances, each with a behavioural memory and scoreboard queue.
module tb_fifo_ctrl;

    logic clk;
    logic rst_ni;

    logic       wv8, rr8, wrdy8, rvld8, wen8, full8, empty8, af8;
    logic [2:0] waddr8, raddr8;
    logic [3:0] cnt8;
    logic [7:0] wdat8;
    logic [7:0] mem8 [8];
    logic [7:0] sb8 [$];

    logic       wv5, rr5, wrdy5, rvld5, wen5, full5, empty5, af5;
    logic [2:0] waddr5, raddr5;
    logic [2:0] cnt5;
    logic [7:0] wdat5;
    logic [7:0] mem5 [5];
    logic [7:0] sb5 [$];

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic ovf8, udf8, ovf5, udf5;
`endif

    int checks = 0;
    int failures = 0;

    fifo_ctrl #(.Depth(8), .AFullThr(6)) u8 (
        .clk_i(clk), .rst_ni(rst_ni),
        .wr_valid_i(wv8), .wr_ready_o(wrdy8),
        .rd_valid_o(rvld8), .rd_ready_i(rr8),
        .mem_w_en_o(wen8), .mem_w_addr_o(waddr8), .mem_r_addr_o(raddr8),
        .count_o(cnt8), .full_o(full8), .empty_o(empty8),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        .ovf_o(ovf8), .udf_o(udf8),
`endif
        .almost_full_o(af8)
    );

    fifo_ctrl #(.Depth(5)) u5 (
        .clk_i(clk), .rst_ni(rst_ni),
        .wr_valid_i(wv5), .wr_ready_o(wrdy5),
        .rd_valid_o(rvld5), .rd_ready_i(rr5),
        .mem_w_en_o(wen5), .mem_w_addr_o(waddr5), .mem_r_addr_o(raddr5),
        .count_o(cnt5), .full_o(full5), .empty_o(empty5),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        .ovf_o(ovf5), .udf_o(udf5),
`endif
        .almost_full_o(af5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fifomem: registered write, asynchronous read.
    always @(posedge clk) begin
        if (wen8) mem8[waddr8] <= wdat8;
        if (wen5) mem5[waddr5] <= wdat5;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_underrun(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: pop with empty scoreboard at %0t", nm, $time);
    endtask

    // Drive inputs, record push/pop against the scoreboard, then advance one edge.
    task automatic step8(input logic wv, input logic rr, input logic [7:0] d, output logic wen);
        logic [7:0] e;
        wv8 = wv; rr8 = rr; wdat8 = d;
        #1;
        wen = wen8;
        if (wen8) sb8.push_back(d);
        if (rr && rvld8) begin
            if (sb8.size() == 0) sb_underrun("rd_data8");
            else begin
                e = sb8.pop_front();
                chk("rd_data8", 32'(mem8[raddr8]), 32'(e));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic step5(input logic wv, input logic rr, input logic [7:0] d, output logic wen);
        logic [7:0] e;
        wv5 = wv; rr5 = rr; wdat5 = d;
        #1;
        wen = wen5;
        if (wen5) sb5.push_back(d);
        if (rr && rvld5) begin
            if (sb5.size() == 0) sb_underrun("rd_data5");
            else begin
                e = sb5.pop_front();
                chk("rd_data5", 32'(mem5[raddr5]), 32'(e));
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       wv;
        logic       rr;
        logic [7:0] d;
        logic       wen;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       afull;
    } vec_t;

    vec_t tbl [18];

    task automatic setv(input int i, input logic wv, input logic rr, input logic [7:0] d,
                        input logic wen, input logic [3:0] cnt, input logic full,
                        input logic empty, input logic afull);
        tbl[i] = '{wv, rr, d, wen, cnt, full, empty, afull};
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_cnt"},   32'(cnt8),   32'd0);
        chk({tag, "_empty"}, 32'(empty8), 32'd1);
        chk({tag, "_full"},  32'(full8),  32'd0);
        chk({tag, "_af"},    32'(af8),    32'd0);
        chk({tag, "_rvld"},  32'(rvld8),  32'd0);
        chk({tag, "_wrdy"},  32'(wrdy8),  32'd1);
        chk({tag, "_waddr"}, 32'(waddr8), 32'd0);
        chk({tag, "_raddr"}, 32'(raddr8), 32'd0);
    endtask

    initial begin
        logic wen;
        rst_ni = 1'b0;
        wv8 = 1'b0; rr8 = 1'b0; wdat8 = '0;
        wv5 = 1'b0; rr5 = 1'b0; wdat5 = '0;

        #12;
        chk_reset8("rst");
        chk("rst_wen8", 32'(wen8), 32'd0);
        chk("rst_cnt5", 32'(cnt5), 32'd0);
        chk("rst_empty5", 32'(empty5), 32'd1);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_udf", 32'(udf8), 32'd0);
`endif
        #8 rst_ni = 1'b1;
        @(posedge clk); #1;

        // Fill to full, attempt overflow, pop-at-full with push request, drain, attempt underflow.
        for (int i = 0; i < 8; i++)
            setv(i, 1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 4'(i + 1), (i == 7), 1'b0, (i >= 5));
        setv(8,  1'b1, 1'b0, 8'h18, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1);
        setv(9,  1'b1, 1'b1, 8'h18, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
        setv(10, 1'b0, 1'b1, 8'h00, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        for (int i = 11; i < 17; i++)
            setv(i, 1'b0, 1'b1, 8'h00, 1'b0, 4'(16 - i), 1'b0, (i == 16), 1'b0);
        setv(17, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 18; i++) begin
            step8(tbl[i].wv, tbl[i].rr, tbl[i].d, wen);
            chk($sformatf("v%0d_wen", i),   32'(wen),   32'(tbl[i].wen));
            chk($sformatf("v%0d_cnt", i),   32'(cnt8),  32'(tbl[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(full8), 32'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 32'(empty8), 32'(tbl[i].empty));
            chk($sformatf("v%0d_af", i),    32'(af8),   32'(tbl[i].afull));
            chk($sformatf("v%0d_wrdy", i),  32'(wrdy8), 32'(!tbl[i].full));
            chk($sformatf("v%0d_rvld", i),  32'(rvld8), 32'(!tbl[i].empty));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
            if (i == 7) chk("ovf_before", 32'(ovf8), 32'd0);
            if (i == 8) chk("ovf_set", 32'(ovf8), 32'd1);
            if (i == 16) chk("udf_before", 32'(udf8), 32'd0);
`endif
        end
        chk("drain_sb8", 32'(sb8.size()), 32'd0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("ovf_sticky", 32'(ovf8), 32'd1);
        chk("udf_set", 32'(udf8), 32'd1);
`endif

        // Both pointers back at 0; push 3 then 10 simultaneous push/pop.
        for (int i = 0; i < 3; i++) step8(1'b1, 1'b0, 8'(8'h20 + i), wen);
        chk("sim_cnt_start", 32'(cnt8), 32'd3);
        for (int k = 0; k < 10; k++) begin
            step8(1'b1, 1'b1, 8'(8'h30 + k), wen);
            chk($sformatf("sim%0d_cnt", k), 32'(cnt8), 32'd3);
        end
        chk("sim_waddr", 32'(waddr8), 32'd5);
        chk("sim_raddr", 32'(raddr8), 32'd2);
        for (int i = 0; i < 3; i++) step8(1'b0, 1'b1, 8'h00, wen);
        chk("sim_empty", 32'(empty8), 32'd1);
        chk("sim_sb8", 32'(sb8.size()), 32'd0);

        // Asynchronous reset mid-cycle with data held and a push requested.
        for (int i = 0; i < 3; i++) step8(1'b1, 1'b0, 8'(8'h50 + i), wen);
        wv8 = 1'b1;
        #1 rst_ni = 1'b0;
        #1 chk_reset8("arst");
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("arst_ovf", 32'(ovf8), 32'd0);
        chk("arst_udf", 32'(udf8), 32'd0);
`endif
        @(posedge clk); #1;
        chk("arst_edge_cnt", 32'(cnt8), 32'd0);
        wv8 = 1'b0;
        sb8.delete();
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;

        // Depth=5 wrap: push 3, pop 3, then push 4 landing at 3,4,0,1.
        for (int i = 0; i < 3; i++) step5(1'b1, 1'b0, 8'(8'h40 + i), wen);
        for (int i = 0; i < 3; i++) step5(1'b0, 1'b1, 8'h00, wen);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap%0d_waddr", k), 32'(waddr5), 32'((3 + k) % 5));
            step5(1'b1, 1'b0, 8'(8'h60 + k), wen);
        end
        chk("wrap_cnt", 32'(cnt5), 32'd4);
        chk("wrap_af5", 32'(af5), 32'd1);
        for (int i = 0; i < 4; i++) step5(1'b0, 1'b1, 8'h00, wen);
        chk("wrap_empty", 32'(empty5), 32'd1);
        chk("wrap_sb5", 32'(sb5.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous single-clock FIFO controller that sequences the team's `fifomem` storage array (`Depth` entries, asynchronous read, registered write).
- Owns read/write pointers, occupancy count and status flags.
- Exposes valid/ready handshakes on the producer and consumer sides, and drives the memory's write-enable, write-address and read-address.
- Sits between CNN pipeline stages, e.g. line/feature buffering ahead of the PE array.

Parameters:
- Depth, 8, number of entries in the attached memory; any integer >= 2, not necessarily a power of two.
- AFullThr, Depth-2, almost_full asserts when count >= AFullThr; legal range 1..Depth.
- AWidth, $clog2(Depth), localparam, memory address width.
- CWidth, $clog2(Depth+1), localparam, occupancy count width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  producer has data to push.
- wr_ready_o  out  1  controller can accept a push (= !full).
- rd_valid_o  out  1  head entry available (= !empty).
- rd_ready_i  in  1  consumer takes the head entry.
- mem_w_en_o  out  1  to memory w_en; = wr_valid_i & wr_ready_o.
- mem_w_addr_o  out  AWidth  to memory w_addr; = wr_ptr.
- mem_r_addr_o  out  AWidth  to memory r_addr; = rd_ptr. Read data flows memory -> consumer directly.
- count_o  out  CWidth  current occupancy, 0..Depth.
- full_o  out  1  count == Depth.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= AFullThr.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs: empty_o = 1, full_o = 0, almost_full_o = 0, rd_valid_o = 0, wr_ready_o = 1, mem_w_en_o = 0 (when no wr_valid), both addresses 0.
- Reset asserted mid-operation discards all contents immediately; no partial transfer completes on that edge.
- push = wr_valid_i & !full; pop = rd_ready_i & !empty. Both are combinational from the current state.
- Handshake rules:
  - wr_valid_i may be held while wr_ready_o = 0; no push occurs in that case.
  - rd_ready_i while empty is ignored.
- Pointer advance: on push, wr_ptr <= (wr_ptr == Depth-1) ? 0 : wr_ptr+1; rd_ptr likewise on pop. Wrap is explicit, so non-power-of-two Depth is legal.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push & pop in the same cycle: unchanged, both pointers advance.
  - neither: hold.
- Status flags are registered, derived from next-count, so they are valid the cycle after the transfer.
- Latency:
  - Data pushed at edge N is readable (rd_valid_o = 1, mem_r_addr_o pointing to it) from cycle N+1.
  - Write-to-read latency is 1 cycle; no fall-through while empty.
- Full boundary:
  - wr_ready_o = 0 even if a pop occurs in the same cycle; no simultaneous push when full.
  - Pop when full -> count Depth-1, wr_ready_o = 1 next cycle.
- Empty boundary:
  - rd_valid_o = 0 and no pop.
  - A push while empty gives count 1 next cycle.
- Overflow and underflow are impossible by construction. Attempted overflow (wr_valid_i & full) and attempted underflow (rd_ready_i & empty) are dropped silently, unless the optional feature is enabled.
- No FSM beyond pointer/count registers; all outputs other than mem_w_en_o are registered or pure functions of registers.

Optional Feature:
- Macro FIFO_CTRL_ERR_FLAGS_EN.
- When defined, adds two output ports:
  - ovf_o (1): sticky; set on any cycle with wr_valid_i & full.
  - udf_o (1): sticky; set on any cycle with rd_ready_i & empty.
- Both ports are cleared only by rst_ni, and set one cycle after the offending cycle.
- When not defined, the ports do not exist and attempted overflow/underflow is silently ignored.
- Core behaviour is identical in both builds.

Test Plan:
- Reset check: assert rst_ni = 0 asynchronously mid-cycle -> immediately empty_o = 1, full_o = 0, count_o = 0, rd_valid_o = 0, wr_ready_o = 1, addresses 0.
- Fill/drain with Depth = 8:
  - 8 back-to-back pushes of 0x10..0x17 -> count_o = 8, full_o = 1, wr_ready_o = 0.
  - A 9th wr_valid produces no mem_w_en_o.
  - Draining reads 0x10..0x17 in order and ends with empty_o = 1.
- Wrap, non-power-of-two Depth = 5: push 3, pop 3, then push 4 -> write addresses 3,4,0,1; reads return in push order; count_o = 4.
- Simultaneous push/pop at count = 3 for 10 cycles -> count_o stays 3, both pointers advance 10 mod Depth, data order preserved.
- Simultaneous at full: full with wr_valid_i = 1 and rd_ready_i = 1 -> pop only, count_o = Depth-1, wr_ready_o = 1 the next cycle.
- Almost-full and error flags (AFullThr = 6):
  - almost_full_o rises on the cycle after the 6th push and falls after the pop to 5.
  - With FIFO_CTRL_ERR_FLAGS_EN: push while full -> ovf_o = 1 and sticky; pop while empty -> udf_o = 1; both clear only on reset.
